// File: rtl/gpmc_pkg.sv
// Shared GPMC master types and default bus timing.
package gpmc_pkg;

  localparam int AD_WIDTH         = 16;
  localparam int DEF_ADDR_CYC     = 2;
  localparam int DEF_ADV_HOLD_CYC = 1;
  localparam int DEF_ACCESS_CYC   = 4;
  localparam int DEF_RECOVER_CYC  = 2;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    HOLD,
    WDATA,
    WEND,
    RTURN,
    RDATA,
    RECOVER
  } gpmc_state_t;

endpackage

// File: rtl/gpmc_master.sv
// GPMC initiator: turns a valid/ready request into one multiplexed
// address/data bus cycle. All bus outputs are registered; they are decoded
// from the next state so they line up with the state register.
module gpmc_master
  import gpmc_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = AD_WIDTH,
  parameter int ADDR_CYC     = DEF_ADDR_CYC,
  parameter int ADV_HOLD_CYC = DEF_ADV_HOLD_CYC,
  parameter int ACCESS_CYC   = DEF_ACCESS_CYC,
  parameter int RECOVER_CYC  = DEF_RECOVER_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  inout  logic [AD_WIDTH-1:0]   gpmc_ad,
  output logic                  gpmc_advn,
  output logic                  gpmc_csn1,
  output logic                  gpmc_wein,
  output logic                  gpmc_oen,
  output logic                  gpmc_clk
);

  gpmc_state_t           state, state_nx;
  logic [7:0]            cnt, cnt_nx;
  logic                  accept;
  logic                  write_r;
  logic [ADDR_WIDTH-1:0] addr_r, addr_src;
  logic [DATA_WIDTH-1:0] wdata_r;

  logic                  ad_oe, ad_oe_nx;
  logic [AD_WIDTH-1:0]   ad_out, ad_out_nx;
  logic                  csn_nx, advn_nx, wein_nx, oen_nx;
  logic                  rd_done;

  assign gpmc_ad = ad_oe ? ad_out : 'z;

  // Phase counter reload value: stay N cycles in a timed state.
  function automatic logic [7:0] load_val(input gpmc_state_t s);
    case (s)
      ADDR:         return 8'(ADDR_CYC - 1);
      HOLD:         return 8'(ADV_HOLD_CYC - 1);
      WDATA, RDATA: return 8'(ACCESS_CYC - 1);
      RECOVER:      return 8'(RECOVER_CYC - 1);
      default:      return '0;
    endcase
  endfunction

  // Next state, phase counter and next bus outputs.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    csn_nx    = 1'b1;
    advn_nx   = 1'b1;
    wein_nx   = 1'b1;
    oen_nx    = 1'b1;
    ad_oe_nx  = 1'b0;
    ad_out_nx = '0;

    case (state)
      IDLE:    if (req_valid && req_ready) begin
                 accept   = 1'b1;
                 state_nx = ADDR;
               end
      ADDR:    if (cnt == '0) state_nx = HOLD;
      HOLD:    if (cnt == '0) state_nx = write_r ? WDATA : RTURN;
      WDATA:   if (cnt == '0) state_nx = WEND;
      WEND:    state_nx = RECOVER;
      RTURN:   state_nx = RDATA;
      RDATA:   if (cnt == '0) state_nx = RECOVER;
      RECOVER: if (cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (state_nx != state) cnt_nx = load_val(state_nx);
    else if (cnt != '0)    cnt_nx = cnt - 8'd1;
    else                   cnt_nx = cnt;

    // the first ADDR cycle is decoded in the accept cycle, before addr_r is loaded
    addr_src = accept ? req_addr : addr_r;
    rd_done  = (state == RDATA) && (state_nx == RECOVER);

    case (state_nx)
      ADDR: begin
        csn_nx   = 1'b0;
        advn_nx  = 1'b0;
        ad_oe_nx = 1'b1;
        ad_out_nx[ADDR_WIDTH-1:0] = addr_src;
      end
      HOLD: begin
        csn_nx   = 1'b0;
        ad_oe_nx = 1'b1;
        ad_out_nx[ADDR_WIDTH-1:0] = addr_src;
      end
      WDATA: begin
        csn_nx    = 1'b0;
        wein_nx   = 1'b0;
        ad_oe_nx  = 1'b1;
        ad_out_nx = wdata_r;
      end
      WEND: begin
        csn_nx    = 1'b0;
        ad_oe_nx  = 1'b1;
        ad_out_nx = wdata_r;
      end
      RTURN:   csn_nx = 1'b0;
      RDATA: begin
        csn_nx = 1'b0;
        oen_nx = 1'b0;
      end
      default: ;
    endcase
  end

  // State register, phase counter and request latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      write_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        write_r <= req_write;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
    end
  end

  // Registered bus, handshake and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpmc_csn1 <= 1'b1;
      gpmc_advn <= 1'b1;
      gpmc_wein <= 1'b1;
      gpmc_oen  <= 1'b1;
      gpmc_clk  <= 1'b0;
      ad_oe     <= 1'b0;
      ad_out    <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      gpmc_csn1 <= csn_nx;
      gpmc_advn <= advn_nx;
      gpmc_wein <= wein_nx;
      gpmc_oen  <= oen_nx;
      gpmc_clk  <= csn_nx ? 1'b0 : ~gpmc_clk;
      ad_oe     <= ad_oe_nx;
      ad_out    <= ad_out_nx;
      req_ready <= (state_nx == IDLE);
      rsp_valid <= rd_done;
      if (rd_done) rsp_rdata <= gpmc_ad;
    end
  end

endmodule

// File: tb/tb_gpmc_master.sv
// Bench for gpmc_master: lane 0 uses default timing, lane 1 all-ones timing.
// Each lane has a waveform-list model that also acts as the bus slave,
// driving the AD bus whenever the master is expected to have released it.
module tb_gpmc_master;
  import gpmc_pkg::*;

  typedef struct packed {
    logic        csn, advn, wein, oen, mdrv, rsp;
    logic [15:0] val, rdat;
  } cyc_t;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [2], req_write [2], req_ready [2], rsp_valid [2];
  logic [9:0]  req_addr  [2];
  logic [15:0] req_wdata [2], rsp_rdata [2];
  logic        advn [2], csn1 [2], wein [2], oen [2], gclk [2];

  int unsigned total, bad;
  int unsigned busy [2], starts [2], advn_lo [2], wein_lo [2], oen_lo [2], rsps [2];
  logic [15:0] first_ad [2];
  logic [15:0] slave_mem [1024];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic cyc_t mk(input logic csn, advn, wein, oen, mdrv, rsp,
                              input logic [15:0] val, rdat);
    cyc_t c;
    c.csn = csn; c.advn = advn; c.wein = wein; c.oen = oen;
    c.mdrv = mdrv; c.rsp = rsp; c.val = val; c.rdat = rdat;
    return c;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int AC = (g == 0) ? 2 : 1;
    localparam int HC = (g == 0) ? 1 : 1;
    localparam int XC = (g == 0) ? 4 : 1;
    localparam int RC = (g == 0) ? 2 : 1;

    wire  [15:0] ad;
    logic        tb_oe;
    logic [15:0] tb_drv;
    assign ad = tb_oe ? tb_drv : 'z;

    gpmc_master #(
      .ADDR_WIDTH(10), .DATA_WIDTH(16), .ADDR_CYC(AC),
      .ADV_HOLD_CYC(HC), .ACCESS_CYC(XC), .RECOVER_CYC(RC)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_write(req_write[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
      .gpmc_ad(ad), .gpmc_advn(advn[g]), .gpmc_csn1(csn1[g]),
      .gpmc_wein(wein[g]), .gpmc_oen(oen[g]), .gpmc_clk(gclk[g])
    );

    cyc_t        q [$];
    cyc_t        cur;
    logic        ready_exp, gclk_exp, seen;
    logic [15:0] rdata_exp;
    logic [15:0] ref_mem [1024];

    // Reference model + slave drive + per-cycle compare.
    initial begin
      logic [15:0] a16;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      cur = mk(1, 1, 1, 1, 0, 0, 16'($urandom), '0);
      ready_exp = 1'b0; gclk_exp = 1'b0; rdata_exp = '0; seen = 1'b0;
      tb_oe = 1'b1; tb_drv = cur.val;
      forever begin
        @(posedge clk);
        if (!rst_n) begin
          seen = 1'b1;
          q.delete();
          cur = mk(1, 1, 1, 1, 0, 0, 16'($urandom), '0);
          ready_exp = 1'b0; gclk_exp = 1'b0; rdata_exp = '0;
        end else begin
          if (ready_exp && req_valid[g]) begin
            a16 = {6'd0, req_addr[g]};
            for (int i = 0; i < AC; i++) q.push_back(mk(0, 0, 1, 1, 1, 0, a16, '0));
            for (int i = 0; i < HC; i++) q.push_back(mk(0, 1, 1, 1, 1, 0, a16, '0));
            if (req_write[g]) begin
              for (int i = 0; i < XC; i++) q.push_back(mk(0, 1, 0, 1, 1, 0, req_wdata[g], '0));
              q.push_back(mk(0, 1, 1, 1, 1, 0, req_wdata[g], '0));
              ref_mem[req_addr[g]] = req_wdata[g];
            end else begin
              q.push_back(mk(0, 1, 1, 1, 0, 0, 16'($urandom), '0));
              for (int i = 0; i < XC; i++) q.push_back(mk(0, 1, 1, 0, 0, 0, ref_mem[req_addr[g]], '0));
            end
            for (int i = 0; i < RC; i++)
              q.push_back(mk(1, 1, 1, 1, 0, (i == 0) && !req_write[g], 16'($urandom),
                             ref_mem[req_addr[g]]));
          end
          if (q.size() > 0) begin
            cur = q.pop_front();
            ready_exp = 1'b0;
          end else begin
            cur = mk(1, 1, 1, 1, 0, 0, 16'($urandom), '0);
            ready_exp = 1'b1;
          end
          gclk_exp = cur.csn ? 1'b0 : ~gclk_exp;
          if (cur.rsp) rdata_exp = cur.rdat;
        end
        #1;
        tb_oe  = !cur.mdrv;
        tb_drv = cur.mdrv ? '0 : cur.val;
        @(negedge clk);
        if (seen) begin
          chk($sformatf("lane%0d csn1", g), 32'(csn1[g]), 32'(cur.csn));
          chk($sformatf("lane%0d advn", g), 32'(advn[g]), 32'(cur.advn));
          chk($sformatf("lane%0d wein", g), 32'(wein[g]), 32'(cur.wein));
          chk($sformatf("lane%0d oen", g), 32'(oen[g]), 32'(cur.oen));
          chk($sformatf("lane%0d ad", g), 32'(ad), 32'(cur.val));
          chk($sformatf("lane%0d gpmc_clk", g), 32'(gclk[g]), 32'(gclk_exp));
          chk($sformatf("lane%0d req_ready", g), 32'(req_ready[g]), 32'(ready_exp));
          chk($sformatf("lane%0d rsp_valid", g), 32'(rsp_valid[g]), 32'(cur.rsp));
          chk($sformatf("lane%0d rsp_rdata", g), 32'(rsp_rdata[g]), 32'(rdata_exp));
          if (csn1[g]) chk($sformatf("lane%0d gpmc_clk_idle_low", g), 32'(gclk[g]), 32'd0);
        end
      end
    end

    // Event counters and an observing slave memory for the literal checks.
    initial begin
      logic       csn_prev;
      logic [9:0] sa;
      csn_prev = 1'b1; sa = '0;
      forever begin
        @(posedge clk);
        #2;
        if (rst_n) begin
          if (!req_ready[g]) busy[g]++;
          if (!csn1[g] && csn_prev) begin
            starts[g]++;
            first_ad[g] = ad;
          end
          if (!advn[g]) advn_lo[g]++;
          if (!wein[g]) wein_lo[g]++;
          if (!oen[g])  oen_lo[g]++;
          if (rsp_valid[g]) rsps[g]++;
          if (g == 0) begin
            if (!csn1[g] && !advn[g]) sa = ad[9:0];
            if (!csn1[g] && !wein[g]) slave_mem[sa] = ad;
          end
        end
        csn_prev = csn1[g];
      end
    end
  end

  task automatic clr(input int g);
    busy[g] = 0; starts[g] = 0; advn_lo[g] = 0; wein_lo[g] = 0; oen_lo[g] = 0; rsps[g] = 0;
  endtask

  task automatic wait_ready(input int g);
    int n;
    n = 0;
    while (!req_ready[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[g]) begin
      total++; bad++;
      $display("FAIL ready_timeout lane%0d: req_ready %0b, required 1", g, req_ready[g]);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int g, input logic w, input logic [9:0] a,
                       input logic [15:0] d, input logic keep);
    req_write[g] = w; req_addr[g] = a; req_wdata[g] = d; req_valid[g] = 1'b1;
    wait_ready(g);
    @(negedge clk);
    if (!keep) req_valid[g] = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 1024; i++) slave_mem[i] = '0;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0; req_write[g] = 1'b0; req_addr[g] = '0; req_wdata[g] = '0;
      clr(g);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready(0);
    wait_ready(1);

    // write 0x005 / 0xBEEF
    clr(0);
    issue(0, 1'b1, 10'h005, 16'hBEEF, 1'b0);
    wait_ready(0);
    chk("wr advn_low_cycles", advn_lo[0], 2);
    chk("wr first_ad", 32'(first_ad[0]), 32'h0005);
    chk("wr wein_low_cycles", wein_lo[0], 4);
    chk("wr busy_cycles", busy[0], 10);
    chk("wr slave_mem5", 32'(slave_mem[5]), 32'hBEEF);

    // read back 0x005
    clr(0);
    issue(0, 1'b0, 10'h005, 16'h0000, 1'b0);
    wait_ready(0);
    chk("rd oen_low_cycles", oen_lo[0], 4);
    chk("rd busy_cycles", busy[0], 10);
    chk("rd rsp_pulses", rsps[0], 1);
    chk("rd rdata", 32'(rsp_rdata[0]), 32'hBEEF);
    repeat (3) @(negedge clk);
    chk("rd rdata_held", 32'(rsp_rdata[0]), 32'hBEEF);

    // back-to-back with req_valid held
    clr(0);
    issue(0, 1'b1, 10'h001, 16'h1111, 1'b1);
    issue(0, 1'b1, 10'h002, 16'h2222, 1'b0);
    wait_ready(0);
    repeat (4) @(negedge clk);
    chk("b2b starts", starts[0], 2);
    chk("b2b busy_cycles", busy[0], 20);
    chk("b2b slave_mem1", 32'(slave_mem[1]), 32'h1111);
    chk("b2b slave_mem2", 32'(slave_mem[2]), 32'h2222);

    // reset during the second WDATA cycle
    req_write[0] = 1'b1; req_addr[0] = 10'h3A0; req_wdata[0] = 16'hCAFE; req_valid[0] = 1'b1;
    wait_ready(0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst csn1", 32'(csn1[0]), 32'd1);
    chk("rst wein", 32'(wein[0]), 32'd1);
    chk("rst req_ready", 32'(req_ready[0]), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
    rst_n = 1'b1;
    wait_ready(0);
    issue(0, 1'b1, 10'h007, 16'h1234, 1'b0);
    issue(0, 1'b0, 10'h007, 16'h0000, 1'b0);
    wait_ready(0);
    chk("post_rst rdata", 32'(rsp_rdata[0]), 32'h1234);

    // all-ones timing lane, top address
    wait_ready(1);
    clr(1);
    issue(1, 1'b1, 10'h3FF, 16'h5A3C, 1'b0);
    wait_ready(1);
    chk("min wr busy_cycles", busy[1], 5);
    chk("min wr first_ad", 32'(first_ad[1]), 32'h03FF);
    clr(1);
    issue(1, 1'b0, 10'h3FF, 16'h0000, 1'b0);
    wait_ready(1);
    chk("min rd busy_cycles", busy[1], 5);
    chk("min rd rdata", 32'(rsp_rdata[1]), 32'h5A3C);
    chk("min rd rsp_pulses", rsps[1], 1);

    // randomized traffic on both lanes
    for (int n = 0; n < 60; n++) begin
      int g;
      g = int'($urandom_range(1, 0));
      issue(g, 1'($urandom), 10'($urandom), 16'($urandom), 1'b0);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    wait_ready(0);
    wait_ready(1);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
